// File: rtl/fog_ramp_scheduler.sv
// ---------------------------------------------------------------------------
// fog_ramp_scheduler
//
// Per-period sequencer for the closed-loop gyro phase ramp (one per axis).
// Generates the square-wave bias modulation (+amp for tau clocks, -amp for
// tau clocks). It demodulates the ADC error over each full modulation period
// and integrates the result into a clamped ladder step. The step, a one-cycle
// trigger and the modulation word drive the phase ramp generator.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst       synchronous active-high reset
//   i_en        run enable; low forces IDLE and flushes pending pulses
//   i_fb_on     closed-loop enable; low zeroes the step at each update
//   i_freq      half-period tau in clocks (>= 4 to run)
//   i_wait      settling clocks skipped at the start of each half-period
//   i_mod_amp   signed modulation amplitude
//   i_err       signed ADC error sample, one per clock
//   i_gain_sft  loop gain as arithmetic right shift of the period error
//   i_v2pi      2pi voltage count; step is clamped to +/-(v2pi-1)
//   o_mod       registered modulation word (+amp / -amp / 0)
//   o_trig      one-cycle pulse, new o_step valid
//   o_step      signed ladder step
//   o_err       signed demodulated error of the last full period
//   o_err_vld   one-cycle pulse, o_err updated
//   o_state     00 IDLE, 01 POS, 10 NEG
// ---------------------------------------------------------------------------
module fog_ramp_scheduler #(
    parameter int ERR_W      = 16,
    parameter int OUTPUT_BIT = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic                         i_fb_on,
    input  logic [31:0]                  i_freq,
    input  logic [31:0]                  i_wait,
    input  logic signed [OUTPUT_BIT-1:0] i_mod_amp,
    input  logic signed [ERR_W-1:0]      i_err,
    input  logic [4:0]                   i_gain_sft,
    input  logic [31:0]                  i_v2pi,
    output logic signed [OUTPUT_BIT-1:0] o_mod,
    output logic                         o_trig,
    output logic signed [31:0]           o_step,
    output logic signed [31:0]           o_err,
    output logic                         o_err_vld,
    output logic [1:0]                   o_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_POS  = 2'b01,
        ST_NEG  = 2'b10
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [31:0]                   cnt;
    logic [31:0]                   cnt_nxt;
    logic signed [31:0]            acc;
    logic signed [31:0]            acc_nxt;
    logic signed [31:0]            acc_upd;
    logic signed [31:0]            err_ext;
    logic signed [OUTPUT_BIT-1:0]  mod_nxt;
    logic                          latch_cfg;
    logic                          period_end;
    logic                          half_last;
    logic                          sample_on;

    // Configuration held constant for a whole modulation period.
    logic [31:0]                   freq_r;
    logic [31:0]                   wait_r;
    logic signed [OUTPUT_BIT-1:0]  amp_r;

    // Step update datapath.
    logic signed [31:0]            err_scaled;
    logic signed [33:0]            step_sum;
    logic signed [33:0]            step_lim;
    logic signed [31:0]            step_new;
    logic                          step_upd;

    assign o_state  = state;
    assign err_ext  = {{(32-ERR_W){i_err[ERR_W-1]}}, i_err};
    assign sample_on = (cnt >= wait_r);
    assign half_last = (cnt == freq_r - 32'd1);

    // The step update happens the cycle after o_err is published, and only
    // if the run is still enabled; dropping i_en flushes the pending update.
    assign step_upd = o_err_vld && i_en;

    // Demodulation: the sample is added during the positive half and
    // subtracted during the negative half, but only once the settling
    // window of the current half-period has passed.
    always_comb begin
        acc_upd = acc;
        if (state == ST_POS && sample_on) begin
            acc_upd = acc + err_ext;
        end else if (state == ST_NEG && sample_on) begin
            acc_upd = acc - err_ext;
        end
    end

    // Next-state logic. o_mod is computed from the next state so that the
    // registered modulation word changes on the same edge as the state.
    // The last NEG cycle closes the period: the accumulator restarts from
    // zero and the configuration is re-latched for the next period. A run
    // enable of zero overrides everything and returns to IDLE.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        acc_nxt    = acc;
        mod_nxt    = o_mod;
        latch_cfg  = 1'b0;
        period_end = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt = 32'd0;
                acc_nxt = 32'sd0;
                mod_nxt = '0;
                if (i_freq >= 32'd4) begin
                    state_nxt = ST_POS;
                    latch_cfg = 1'b1;
                    mod_nxt   = i_mod_amp;
                end
            end

            ST_POS: begin
                acc_nxt = acc_upd;
                if (half_last) begin
                    state_nxt = ST_NEG;
                    cnt_nxt   = 32'd0;
                    mod_nxt   = -amp_r;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end

            ST_NEG: begin
                acc_nxt = acc_upd;
                if (half_last) begin
                    period_end = 1'b1;
                    cnt_nxt    = 32'd0;
                    acc_nxt    = 32'sd0;
                    // An out-of-range half-period cannot be latched into a
                    // running loop, so the sequencer parks in IDLE instead.
                    if (i_freq >= 32'd4) begin
                        state_nxt = ST_POS;
                        latch_cfg = 1'b1;
                        mod_nxt   = i_mod_amp;
                    end else begin
                        state_nxt = ST_IDLE;
                        mod_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 32'd0;
                acc_nxt   = 32'sd0;
                mod_nxt   = '0;
            end
        endcase

        if (!i_en) begin
            state_nxt  = ST_IDLE;
            cnt_nxt    = 32'd0;
            acc_nxt    = 32'sd0;
            mod_nxt    = '0;
            latch_cfg  = 1'b0;
            period_end = 1'b0;
        end
    end

    // Step computation: integrate the scaled period error in 33+ bits so the
    // sum cannot overflow, then clamp symmetrically to one 2pi count minus
    // one. A zero 2pi count collapses the clamp window to zero.
    always_comb begin
        err_scaled = o_err >>> i_gain_sft;
        step_sum   = 34'(o_step) + 34'(err_scaled);
        if (i_v2pi == 32'd0) begin
            step_lim = 34'sd0;
        end else begin
            step_lim = $signed({2'b00, i_v2pi}) - 34'sd1;
        end

        if (step_sum > step_lim) begin
            step_new = step_lim[31:0];
        end else if (step_sum < -step_lim) begin
            step_new = step_new_neg(step_lim);
        end else begin
            step_new = step_sum[31:0];
        end
    end

    function automatic logic signed [31:0] step_new_neg(input logic signed [33:0] lim);
        logic signed [33:0] neg;
        neg = -lim;
        return neg[31:0];
    endfunction

    // Sequencer state, accumulator and latched configuration.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            cnt    <= 32'd0;
            acc    <= 32'sd0;
            o_mod  <= '0;
            freq_r <= 32'd0;
            wait_r <= 32'd0;
            amp_r  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            o_mod <= mod_nxt;
            if (latch_cfg) begin
                freq_r <= i_freq;
                wait_r <= i_wait;
                amp_r  <= i_mod_amp;
            end
        end
    end

    // Output pipeline: the period error (including the final NEG sample)
    // is published one cycle after the period closes, and the step follows
    // one cycle later together with the trigger. The trigger fires every
    // period even in open loop, where the step is forced to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err     <= 32'sd0;
            o_err_vld <= 1'b0;
            o_step    <= 32'sd0;
            o_trig    <= 1'b0;
        end else begin
            o_err_vld <= period_end;
            if (period_end) begin
                o_err <= acc_upd;
            end
            o_trig <= step_upd;
            if (step_upd) begin
                o_step <= i_fb_on ? step_new : 32'sd0;
            end
        end
    end

endmodule

// File: tb/tb_fog_ramp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fog_ramp_scheduler
//
// Directed scoreboard bench for fog_ramp_scheduler. Each test pushes its
// hand-computed period errors and ladder steps into queues; a monitor pops
// and compares them whenever the DUT pulses o_err_vld or o_trig.
// ---------------------------------------------------------------------------
module tb_fog_ramp_scheduler;

    logic               clk;
    logic               i_rst;
    logic               i_en;
    logic               i_fb_on;
    logic [31:0]        i_freq;
    logic [31:0]        i_wait;
    logic signed [15:0] i_mod_amp;
    logic signed [15:0] i_err;
    logic [4:0]         i_gain_sft;
    logic [31:0]        i_v2pi;
    logic signed [15:0] o_mod;
    logic               o_trig;
    logic signed [31:0] o_step;
    logic signed [31:0] o_err;
    logic               o_err_vld;
    logic [1:0]         o_state;

    logic signed [15:0] err_pos;
    logic signed [15:0] err_neg;

    int checks   = 0;
    int failures = 0;

    longint err_q[$];
    longint step_q[$];

    int cyc        = 0;
    int last_vld   = -1;
    int prev_vld   = 0;
    int trig_count = 0;
    int vld_count  = 0;
    int cur_freq   = 8;

    fog_ramp_scheduler #(.ERR_W(16), .OUTPUT_BIT(16)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_fb_on    (i_fb_on),
        .i_freq     (i_freq),
        .i_wait     (i_wait),
        .i_mod_amp  (i_mod_amp),
        .i_err      (i_err),
        .i_gain_sft (i_gain_sft),
        .i_v2pi     (i_v2pi),
        .o_mod      (o_mod),
        .o_trig     (o_trig),
        .o_step     (o_step),
        .o_err      (o_err),
        .o_err_vld  (o_err_vld),
        .o_state    (o_state)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The ADC error follows the modulation half, like a real sensor would.
    assign i_err = (o_state == 2'b01) ? err_pos : err_neg;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Loads one configuration onto the DUT inputs.
    task automatic applyStimulus(input int freq, input int wt, input int amp, input int gain,
                                 input int v2pi, input logic fb, input int ep, input int en_neg);
        i_freq     = freq;
        i_wait     = wt;
        i_mod_amp  = 16'(amp);
        i_gain_sft = 5'(gain);
        i_v2pi     = v2pi;
        i_fb_on    = fb;
        err_pos    = 16'(ep);
        err_neg    = 16'(en_neg);
        cur_freq   = freq;
    endtask

    task automatic stepClk();
        @(posedge clk);
        #2;
    endtask

    task automatic applyReset();
        i_rst = 1'b1;
        i_en  = 1'b0;
        repeat (3) stepClk();
        i_rst = 1'b0;
    endtask

    task automatic waitTrig(input int n);
        int target;
        int budget;
        target = trig_count + n;
        budget = 3000;
        while (trig_count < target && budget > 0) begin
            stepClk();
            budget--;
        end
        checkOutput("trig_wait_done", (trig_count >= target) ? 1 : 0, 1);
    endtask

    task automatic endRun();
        i_en = 1'b0;
        repeat (4) stepClk();
        checkOutput("scoreboard_drain", err_q.size() + step_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (i_rst) begin
            last_vld = -1;
        end
        if (o_trig) begin
            trig_count++;
            checkOutput("trig_after_vld", prev_vld, 1);
            if (step_q.size() == 0) begin
                checkOutput("unexpected_trig_step", o_step, -1);
            end else begin
                checkOutput("o_step", o_step, step_q.pop_front());
            end
        end
        if (o_err_vld) begin
            vld_count++;
            if (last_vld >= 0) begin
                checkOutput("vld_spacing", cyc - last_vld, 2 * cur_freq);
            end
            last_vld = cyc;
            if (err_q.size() == 0) begin
                checkOutput("unexpected_err_vld", o_err, -1);
            end else begin
                checkOutput("o_err", o_err, err_q.pop_front());
            end
        end
        prev_vld = o_err_vld ? 1 : 0;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_rst = 1'b1;
        i_en  = 1'b0;
        applyStimulus(8, 2, 1000, 2, 5000, 1'b1, 50, -50);
        repeat (3) stepClk();
        checkOutput("reset_state", o_state, 0);
        checkOutput("reset_mod", o_mod, 0);
        checkOutput("reset_step", o_step, 0);
        checkOutput("reset_err", o_err, 0);
        checkOutput("reset_trig", o_trig, 0);
        i_rst = 1'b0;
        stepClk();

        // Constant error: demodulates to zero; modulation square wave.
        $display("[TB] constant error, modulation shape");
        applyStimulus(8, 2, 1000, 0, 5000, 1'b1, 100, 100);
        for (int k = 0; k < 3; k++) begin
            err_q.push_back(0);
            step_q.push_back(0);
        end
        i_en = 1'b1;
        stepClk();
        for (int k = 0; k < 16; k++) begin
            checkOutput("mod_shape", o_mod, (k < 8) ? 1000 : -1000);
            checkOutput("state_shape", o_state, (k < 8) ? 1 : 2);
            stepClk();
        end
        waitTrig(3);
        endRun();
        applyReset();

        // Balanced demod: 600 per period, step grows by 150.
        $display("[TB] closed loop integration");
        applyStimulus(8, 2, 1000, 2, 5000, 1'b1, 50, -50);
        for (int k = 1; k <= 5; k++) begin
            err_q.push_back(600);
            step_q.push_back(150 * k);
        end
        i_en = 1'b1;
        waitTrig(5);
        endRun();
        applyReset();

        // Positive clamp at v2pi-1.
        $display("[TB] positive clamp");
        applyStimulus(8, 2, 1000, 2, 1000, 1'b1, 50, -50);
        for (int k = 1; k <= 8; k++) begin
            err_q.push_back(600);
            step_q.push_back((k <= 6) ? 150 * k : 999);
        end
        i_en = 1'b1;
        waitTrig(8);
        endRun();
        applyReset();

        // Negative clamp with inverted error sign.
        $display("[TB] negative clamp");
        applyStimulus(8, 2, 1000, 2, 1000, 1'b1, -50, 50);
        for (int k = 1; k <= 8; k++) begin
            err_q.push_back(-600);
            step_q.push_back((k <= 6) ? -150 * k : -999);
        end
        i_en = 1'b1;
        waitTrig(8);
        endRun();
        applyReset();

        // Open loop holds the step at zero; closing the loop resumes.
        $display("[TB] open loop then closed loop");
        applyStimulus(8, 2, 1000, 2, 5000, 1'b0, 50, -50);
        for (int k = 1; k <= 6; k++) begin
            err_q.push_back(600);
            step_q.push_back((k <= 3) ? 0 : 150 * (k - 3));
        end
        i_en = 1'b1;
        waitTrig(3);
        i_fb_on = 1'b1;
        waitTrig(3);
        endRun();
        applyReset();

        // Disable mid-NEG: immediate IDLE, no more pulses, step held.
        $display("[TB] disable mid-period");
        applyStimulus(8, 2, 1000, 2, 5000, 1'b1, 50, -50);
        err_q.push_back(600);
        step_q.push_back(150);
        i_en = 1'b1;
        waitTrig(1);
        begin
            int budget;
            budget = 100;
            while (o_state != 2'b10 && budget > 0) begin
                stepClk();
                budget--;
            end
            checkOutput("reached_neg", o_state, 2);
        end
        repeat (3) stepClk();
        i_en = 1'b0;
        begin
            int vld_before;
            int trig_before;
            vld_before  = vld_count;
            trig_before = trig_count;
            stepClk();
            checkOutput("disable_state", o_state, 0);
            checkOutput("disable_mod", o_mod, 0);
            checkOutput("disable_step_held", o_step, 150);
            repeat (40) stepClk();
            checkOutput("no_late_vld", vld_count - vld_before, 0);
            checkOutput("no_late_trig", trig_count - trig_before, 0);
            checkOutput("disable_err_held", o_err, 600);
        end

        // Half-period below the minimum keeps the sequencer idle.
        applyStimulus(3, 0, 1000, 2, 5000, 1'b1, 50, -50);
        i_en = 1'b1;
        repeat (10) stepClk();
        checkOutput("short_freq_idle", o_state, 0);
        checkOutput("short_freq_mod", o_mod, 0);
        endRun();
        applyReset();

        // Reset mid-run with enable still high: reset wins.
        $display("[TB] reset mid-run");
        applyStimulus(8, 2, 1000, 2, 5000, 1'b1, 50, -50);
        err_q.push_back(600);
        step_q.push_back(150);
        err_q.push_back(600);
        step_q.push_back(300);
        i_en = 1'b1;
        waitTrig(2);
        repeat (5) stepClk();
        i_rst = 1'b1;
        stepClk();
        checkOutput("midreset_state", o_state, 0);
        checkOutput("midreset_mod", o_mod, 0);
        checkOutput("midreset_step", o_step, 0);
        checkOutput("midreset_err", o_err, 0);
        checkOutput("midreset_trig", o_trig, 0);
        checkOutput("midreset_vld", o_err_vld, 0);
        repeat (2) stepClk();
        i_en  = 1'b0;
        i_rst = 1'b0;
        endRun();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
